// File: rtl/pwm_pkg.sv
// Shared constants, FSM state type and output-polarity helper for the PWM generator.
package pwm_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } pwm_state_e;

  // Map a logical "active" request onto the physical output level.
  function automatic logic pwm_level(input logic active, input bit active_high);
    return active_high ? active : ~active;
  endfunction

endpackage

// File: rtl/pwm_gen_4bit_if.sv
// Bus between the PWM generator and its host: count stream, duty handshake and status outputs.
interface pwm_gen_4bit_if #(
  parameter int CNT_W = pwm_pkg::CNT_W_DEF
);
  logic [CNT_W-1:0] count_in;
  logic             en;
  logic             duty_valid;
  logic [CNT_W-1:0] duty_data;
  logic             duty_ready;
  logic             pwm_out;
  logic             period_start;
  logic             update_done;
  logic             seq_err;

  modport master (
    output count_in, en, duty_valid, duty_data,
    input  duty_ready, pwm_out, period_start, update_done, seq_err
  );

  modport slave (
    input  count_in, en, duty_valid, duty_data,
    output duty_ready, pwm_out, period_start, update_done, seq_err
  );
endinterface

// File: rtl/cnt_wrap_detect.sv
// Tracks the previous count sample, flags the MAX->0 wrap and any step that is not exactly +1.
module cnt_wrap_detect #(
  parameter int CNT_W = pwm_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count_in,
  output logic             wrap,
  output logic             seq_break
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] prev_cnt_q;
  logic [CNT_W-1:0] prev_cnt_d;
  logic [CNT_W-1:0] expected_cnt;

  always_comb begin
    prev_cnt_d   = count_in;
    expected_cnt = prev_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cnt_q <= '0;
    end else begin
      prev_cnt_q <= prev_cnt_d;
    end
  end

  assign wrap      = (prev_cnt_q == CNT_MAX) && (count_in == '0);
  assign seq_break = (count_in != expected_cnt);

endmodule

// File: rtl/pwm_gen_4bit.sv
// PWM generator slaved to an external up-counter, with double-buffered duty updated at period wrap.
module pwm_gen_4bit
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  pwm_gen_4bit_if.slave bus
);
  localparam logic INACTIVE_LVL = pwm_level(1'b0, ACTIVE_HIGH);

  logic wrap;
  logic seq_break;

  cnt_wrap_detect #(
    .CNT_W(CNT_W)
  ) u_wrap_detect (
    .clk      (clk),
    .rst      (rst),
    .count_in (bus.count_in),
    .wrap     (wrap),
    .seq_break(seq_break)
  );

  pwm_state_e       state_q,        state_d;
  logic             was_live_q,     was_live_d;
  logic [CNT_W-1:0] shadow_q,       shadow_d;
  logic [CNT_W-1:0] active_duty_q,  active_duty_d;
  logic             pending_q,      pending_d;
  logic             pwm_q,          pwm_d;
  logic             period_start_q, period_start_d;
  logic             update_done_q,  update_done_d;
  logic             seq_err_q,      seq_err_d;

  logic             live;
  logic             take;
  logic             apply;
  logic [CNT_W-1:0] duty_eff;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.en) state_d = ARMED;
      ARMED:   if (wrap)   state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (!bus.en) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    live  = (state_q != IDLE);
    take  = bus.duty_valid && !pending_q;
    // A value accepted on the wrap cycle itself cannot be applied there: pending_q is still 0.
    apply = live && wrap && pending_q;

    duty_eff = (wrap && pending_q) ? shadow_q : active_duty_q;

    shadow_d      = take  ? bus.duty_data : shadow_q;
    active_duty_d = apply ? shadow_q      : active_duty_q;
    pending_d     = pending_q;
    if (apply) begin
      pending_d = 1'b0;
    end else if (take) begin
      pending_d = 1'b1;
    end

    // Keyed off the next state so the output register lines up with the state register.
    pwm_d = pwm_level((state_d == RUN) && (bus.count_in < duty_eff), ACTIVE_HIGH);

    period_start_d = live && wrap;
    update_done_d  = apply;
    was_live_d     = live;

    seq_err_d = seq_err_q | (live && was_live_q && seq_break);
    if (state_d == IDLE) begin
      seq_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      was_live_q     <= 1'b0;
      shadow_q       <= '0;
      active_duty_q  <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= INACTIVE_LVL;
      period_start_q <= 1'b0;
      update_done_q  <= 1'b0;
      seq_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      was_live_q     <= was_live_d;
      shadow_q       <= shadow_d;
      active_duty_q  <= active_duty_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      update_done_q  <= update_done_d;
      seq_err_q      <= seq_err_d;
    end
  end

  assign bus.duty_ready   = !pending_q;
  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = period_start_q;
  assign bus.update_done  = update_done_q;
  assign bus.seq_err      = seq_err_q;

endmodule

// File: tb/tb_pwm_gen_4bit.sv
// Self-checking bench: two instances (active-high and active-low) driven in lockstep against a reference model.
module tb_pwm_gen_4bit;
  import pwm_pkg::*;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_gen_4bit_if #(.CNT_W(W)) if_h ();
  pwm_gen_4bit_if #(.CNT_W(W)) if_l ();

  pwm_gen_4bit #(.CNT_W(W), .ACTIVE_HIGH(1'b1)) dut_h (.clk(clk), .rst(rst), .bus(if_h));
  pwm_gen_4bit #(.CNT_W(W), .ACTIVE_HIGH(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(if_l));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cur_cnt  = 0;

  // Reference model: mode 0 = idle, 1 = waiting for first wrap, 2 = generating.
  int m_mode, m_prev, m_shadow, m_active;
  bit m_was_live, m_pending;
  bit e_pwm, e_ps, e_upd, e_seq;

  typedef struct {
    int cnt; bit en; bit v; int d;
    bit pwm; bit ps; bit upd; bit rdy; bit seq;
  } vec_t;
  vec_t tbl[32];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0b expected %0b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic reset_model();
    m_mode = 0; m_prev = 0; m_shadow = 0; m_active = 0;
    m_was_live = 1'b0; m_pending = 1'b0;
    e_pwm = 1'b0; e_ps = 1'b0; e_upd = 1'b0; e_seq = 1'b0;
  endtask

  task automatic model_step(input int cnt, input bit en, input bit v, input int d);
    bit wrap, live, apply, take;
    int eff, nxt;
    wrap  = (m_prev == MAXV) && (cnt == 0);
    live  = (m_mode != 0);
    apply = live && wrap && m_pending;
    take  = v && !m_pending;
    eff   = apply ? m_shadow : m_active;
    if (!en)                     nxt = 0;
    else if (m_mode == 0)        nxt = 1;
    else if (m_mode == 1 && wrap) nxt = 2;
    else                         nxt = m_mode;
    e_pwm = (nxt == 2) && (cnt < eff);
    e_ps  = live && wrap;
    e_upd = apply;
    if (live && m_was_live && cnt != (m_prev + 1) % (MAXV + 1)) e_seq = 1'b1;
    if (nxt == 0) e_seq = 1'b0;
    if (apply) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    if (take) begin
      m_shadow  = d;
      m_pending = 1'b1;
    end
    m_was_live = live;
    m_prev     = cnt;
    m_mode     = nxt;
  endtask

  // Called just after a falling edge; applies inputs, clocks once, compares at the next falling edge.
  task automatic drive(input int cnt, input bit en, input bit v, input int d);
    if_h.count_in = W'(cnt); if_h.en = en; if_h.duty_valid = v; if_h.duty_data = W'(d);
    if_l.count_in = W'(cnt); if_l.en = en; if_l.duty_valid = v; if_l.duty_data = W'(d);
    model_step(cnt, en, v, d);
    cur_cnt = cnt;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("pwm_h",   if_h.pwm_out,      e_pwm);
    chk("pwm_l",   if_l.pwm_out,      !e_pwm);
    chk("ready_h", if_h.duty_ready,   !m_pending);
    chk("ready_l", if_l.duty_ready,   !m_pending);
    chk("pstart",  if_h.period_start, e_ps);
    chk("upd",     if_h.update_done,  e_upd);
    chk("seq",     if_h.seq_err,      e_seq);
    chk("pstart_l", if_l.period_start, e_ps);
    chk("upd_l",   if_l.update_done,  e_upd);
    chk("seq_l",   if_l.seq_err,      e_seq);
    $display("cyc=%0d cnt=%0d en=%0b v=%0b d=%0d | pwm=%0b/%0b rdy=%0b ps=%0b upd=%0b seq=%0b",
             cyc, cnt, en, v, d, if_h.pwm_out, if_l.pwm_out, if_h.duty_ready,
             if_h.period_start, if_h.update_done, if_h.seq_err);
  endtask

  task automatic tick(input int cnt);
    drive(cnt, 1'b1, 1'b0, 0);
  endtask

  // Precondition: the wrap cycle was just clocked; samples counts 0..MAX of the new period.
  task automatic period_actives(output int ah, output int al);
    ah = (if_h.pwm_out === 1'b1) ? 1 : 0;
    al = (if_l.pwm_out === 1'b0) ? 1 : 0;
    for (int c = 1; c <= MAXV; c++) begin
      tick(c);
      if (if_h.pwm_out === 1'b1) ah++;
      if (if_l.pwm_out === 1'b0) al++;
    end
  endtask

  // Precondition: last count driven was MAX. Ends just after the wrap that applies d.
  task automatic load_duty(input int d);
    tick(0);
    drive(1, 1'b1, 1'b1, d);
    for (int c = 2; c <= MAXV; c++) tick(c);
    tick(0);
    chk("load_upd", if_h.update_done, 1'b1);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_pwm_h",  if_h.pwm_out,      1'b0);
    chk("rst_pwm_l",  if_l.pwm_out,      1'b1);
    chk("rst_ready",  if_h.duty_ready,   1'b1);
    chk("rst_ready_l", if_l.duty_ready,  1'b1);
    chk("rst_pstart", if_h.period_start, 1'b0);
    chk("rst_upd",    if_h.update_done,  1'b0);
    chk("rst_seq",    if_h.seq_err,      1'b0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ah, al;
    rst = 1'b1;
    if_h.count_in = '0; if_h.en = 1'b0; if_h.duty_valid = 1'b0; if_h.duty_data = '0;
    if_l.count_in = '0; if_l.en = 1'b0; if_l.duty_valid = 1'b0; if_l.duty_data = '0;
    reset_model();

    // Directed table: load duty 5 in idle, arm, run two periods.
    for (int k = 0; k < 32; k++) begin
      tbl[k].cnt = (k + 1) % (MAXV + 1);
      tbl[k].en  = 1'b1;
      tbl[k].v   = (k == 0);
      tbl[k].d   = (k == 0) ? 5 : 0;
      tbl[k].seq = 1'b0;
      if (k < 15) begin
        tbl[k].pwm = 1'b0; tbl[k].ps = 1'b0; tbl[k].upd = 1'b0; tbl[k].rdy = 1'b0;
      end else begin
        tbl[k].pwm = (tbl[k].cnt < 5);
        tbl[k].ps  = (tbl[k].cnt == 0);
        tbl[k].upd = (k == 15);
        tbl[k].rdy = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    chk("reset_pwm_h", if_h.pwm_out,      1'b0);
    chk("reset_pwm_l", if_l.pwm_out,      1'b1);
    chk("reset_ready", if_h.duty_ready,   1'b1);
    chk("reset_ps",    if_h.period_start, 1'b0);
    chk("reset_upd",   if_h.update_done,  1'b0);
    chk("reset_seq",   if_h.seq_err,      1'b0);
    rst = 1'b0;

    for (int k = 0; k < 32; k++) begin
      drive(tbl[k].cnt, tbl[k].en, tbl[k].v, tbl[k].d);
      chk("tbl_pwm",   if_h.pwm_out,      tbl[k].pwm);
      chk("tbl_ps",    if_h.period_start, tbl[k].ps);
      chk("tbl_upd",   if_h.update_done,  tbl[k].upd);
      chk("tbl_ready", if_h.duty_ready,   tbl[k].rdy);
      chk("tbl_seq",   if_h.seq_err,      tbl[k].seq);
    end

    // Mid-period update from 5 to 12.
    for (int c = 1; c <= 5; c++) tick(c);
    drive(6, 1'b1, 1'b1, 12);
    chk("upd12_ready_drop", if_h.duty_ready, 1'b0);
    for (int c = 7; c <= MAXV; c++) tick(c);
    tick(0);
    chk("upd12_done",  if_h.update_done, 1'b1);
    chk("upd12_ready", if_h.duty_ready,  1'b1);
    period_actives(ah, al);
    chk_int("duty12_active", ah, 12);

    // Transfer on the wrap cycle itself is deferred one period.
    drive(0, 1'b1, 1'b1, 3);
    chk("wrapxfer_ps1",     if_h.period_start, 1'b1);
    chk("wrapxfer_noapply", if_h.update_done,  1'b0);
    period_actives(ah, al);
    chk_int("wrapxfer_still12", ah, 12);
    tick(0);
    chk("wrapxfer_upd", if_h.update_done,  1'b1);
    chk("wrapxfer_ps2", if_h.period_start, 1'b1);
    period_actives(ah, al);
    chk_int("duty3_active", ah, 3);

    // Duty boundaries on both polarities.
    load_duty(0);
    period_actives(ah, al);
    chk_int("duty0_active_h", ah, 0);
    chk_int("duty0_active_l", al, 0);
    load_duty(MAXV);
    period_actives(ah, al);
    chk_int("dutymax_active_h", ah, MAXV);
    chk_int("dutymax_active_l", al, MAXV);

    // Sequence error: 7 -> 9 jump is sticky until idle.
    for (int c = 0; c <= 7; c++) tick(c);
    tick(9);
    chk("seq_set", if_h.seq_err, 1'b1);
    for (int c = 10; c <= MAXV; c++) tick(c);
    tick(0);
    chk("seq_sticky", if_h.seq_err, 1'b1);
    drive(1, 1'b0, 1'b0, 0);
    chk("seq_clear_idle", if_h.seq_err, 1'b0);
    chk("idle_pwm_h",     if_h.pwm_out, 1'b0);
    chk("idle_pwm_l",     if_l.pwm_out, 1'b1);
    for (int c = 2; c <= MAXV; c++) tick(c);
    tick(0);

    // Async reset mid-period with a pending duty.
    for (int c = 1; c <= 6; c++) tick(c);
    drive(7, 1'b1, 1'b1, 7);
    tick(8);
    chk("pre_rst_pending", if_h.duty_ready, 1'b0);
    async_reset();
    for (int c = 9; c <= MAXV; c++) tick(c);
    tick(0);
    chk("rst_pending_lost", if_h.update_done, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int nc;
      bit en, v;
      nc = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, MAXV)) : (cur_cnt + 1) % (MAXV + 1);
      en = ($urandom_range(0, 59) != 0);
      v  = ($urandom_range(0, 2) == 0);
      drive(nc, en, v, int'($urandom_range(0, MAXV)));
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
